// File: rtl/fw_meta_reporter.sv
// Two-requester arbiter that emits a 6-byte FW metadata packet (sync, major,
// minor, patch, seq, xor checksum) on a valid/ready byte stream per grant.
module fw_meta_reporter #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter bit         RR_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ver_major,
    input  logic [7:0] ver_minor,
    input  logic [7:0] ver_patch,
    input  logic       req_a,
    input  logic       req_b,
    output logic       grant_a,
    output logic       grant_b,
    output logic       done_a,
    output logic       done_b,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic [1:0] state_dbg
);

    // Stream handshake: a byte moves on every rising edge where out_valid and
    // out_ready are both high; out_valid, out_data and out_last hold otherwise.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       start;
    logic       pick_b;
    logic [2:0] idx;
    logic       owner_b;
    logic       prio_b;
    logic [7:0] seq;
    logic [7:0] snap_major;
    logic [7:0] snap_minor;
    logic [7:0] snap_patch;
    logic [7:0] snap_seq;
    logic [7:0] checksum;
    logic [7:0] cur_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        pick_b   = 1'b0;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    start    = 1'b1;
                    state_nx = SEND;
                    if (req_a && req_b) begin
                        pick_b = RR_ENABLE & prio_b;
                    end else begin
                        pick_b = req_b;
                    end
                end
            end
            SEND: begin
                if (out_ready && (idx == 3'd5)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Snapshot at grant keeps every byte of a packet from the same version set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 3'd0;
            owner_b    <= 1'b0;
            prio_b     <= 1'b0;
            seq        <= 8'h00;
            snap_major <= 8'h00;
            snap_minor <= 8'h00;
            snap_patch <= 8'h00;
            snap_seq   <= 8'h00;
        end else begin
            if (start) begin
                snap_major <= ver_major;
                snap_minor <= ver_minor;
                snap_patch <= ver_patch;
                snap_seq   <= seq;
                idx        <= 3'd0;
                owner_b    <= pick_b;
            end
            if ((state == SEND) && out_ready && (idx != 3'd5)) begin
                idx <= idx + 3'd1;
            end
            if (state == DONE) begin
                seq <= seq + 8'd1;
                if (RR_ENABLE) begin
                    prio_b <= ~owner_b;
                end
            end
        end
    end

    assign checksum = SYNC_BYTE ^ snap_major ^ snap_minor ^ snap_patch ^ snap_seq;

    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = snap_major;
            3'd2:    cur_byte = snap_minor;
            3'd3:    cur_byte = snap_patch;
            3'd4:    cur_byte = snap_seq;
            3'd5:    cur_byte = checksum;
            default: cur_byte = 8'h00;
        endcase
    end

    // Outputs decode registered state only, so reset clears them at once.
    assign out_valid = (state == SEND);
    assign out_data  = out_valid ? cur_byte : 8'h00;
    assign out_last  = out_valid && (idx == 3'd5);
    assign grant_a   = out_valid && !owner_b;
    assign grant_b   = out_valid && owner_b;
    assign done_a    = (state == DONE) && !owner_b;
    assign done_b    = (state == DONE) && owner_b;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_fw_meta_reporter.sv
// Self-checking bench for fw_meta_reporter: a byte scoreboard fed at request
// time and drained by a stream monitor, plus directed arbitration/reset cases.
module tb_fw_meta_reporter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ver_major, ver_minor, ver_patch;
    logic       req_a, req_b, out_ready;
    logic       grant_a, grant_b, done_a, done_b, out_valid, out_last, busy;
    logic [7:0] out_data;
    logic [1:0] state_dbg;

    logic       req_a2, req_b2;
    logic       grant_a2, grant_b2, done_a2, done_b2, out_valid2, out_last2, busy2;
    logic [7:0] out_data2;
    logic [1:0] state_dbg2;

    int         tests = 0;
    int         fails = 0;
    logic [9:0] exp_q[$];
    logic [7:0] model_seq;
    logic [7:0] last_pkt[6];

    always #5 clk = ~clk;

    fw_meta_reporter #(.SYNC_BYTE(8'hA5), .RR_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst), .ver_major(ver_major), .ver_minor(ver_minor),
        .ver_patch(ver_patch), .req_a(req_a), .req_b(req_b), .grant_a(grant_a),
        .grant_b(grant_b), .done_a(done_a), .done_b(done_b), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .state_dbg(state_dbg)
    );

    fw_meta_reporter #(.SYNC_BYTE(8'hA5), .RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .ver_major(ver_major), .ver_minor(ver_minor),
        .ver_patch(ver_patch), .req_a(req_a2), .req_b(req_b2), .grant_a(grant_a2),
        .grant_b(grant_b2), .done_a(done_a2), .done_b(done_b2), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_last(out_last2),
        .busy(busy2), .state_dbg(state_dbg2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_packet(input bit side, input logic [7:0] s);
        logic [7:0] b[6];
        b[0] = 8'hA5;
        b[1] = ver_major;
        b[2] = ver_minor;
        b[3] = ver_patch;
        b[4] = s;
        b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({side, (i == 5), b[i]});
            last_pkt[i] = b[i];
        end
    endtask

    // Inputs settle at the falling edge; sample 2 time units later.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", exp_q.size(), 1);
            end else begin
                check_eq("byte", {22'd0, grant_b, out_last, out_data}, {22'd0, exp_q.pop_front()});
                check_eq("grant_excl", grant_a & grant_b, 0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_outs"}, {grant_a, grant_b, done_a, done_b, out_valid, out_last, busy, out_data}, 0);
        check_eq({tag, "_state"}, state_dbg, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_seq = 8'h00;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    task automatic wait_done(input bit side, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (side ? done_b : done_a) ok = 1'b1;
        end
    endtask

    task automatic run_packet(input bit side, input int stall_at, input int stall_len,
                              input int chg_at, input logic [7:0] new_patch, output int cyc);
        bit got;
        push_packet(side, model_seq);
        @(negedge clk);
        if (side) req_b = 1'b1; else req_a = 1'b1;
        cyc = 0;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check_eq("first_grant", side ? grant_b : grant_a, 1);
                check_eq("first_byte", {out_valid, out_data}, {1'b1, 8'hA5});
            end
            if (stall_len > 0 && k == stall_at) out_ready = 1'b0;
            if (stall_len > 0 && k == stall_at + stall_len) out_ready = 1'b1;
            if (!out_ready) begin
                check_eq("stall_data", out_data, last_pkt[stall_at-1]);
                check_eq("stall_valid", out_valid, 1);
            end
            if (chg_at != 0 && k == chg_at) ver_patch = new_patch;
            if (side ? done_b : done_a) begin
                got = 1'b1;
                cyc = k;
            end
        end
        if (side) req_b = 1'b0; else req_a = 1'b0;
        model_seq = model_seq + 8'd1;
        @(negedge clk);
        check_eq("done_one_cycle", side ? done_b : done_a, 0);
        check_eq("idle_after_done", busy, 0);
    endtask

    task automatic run_both(input bit first_b);
        bit ok;
        push_packet(first_b, model_seq);
        push_packet(!first_b, model_seq + 8'd1);
        @(negedge clk);
        req_a = 1'b1;
        req_b = 1'b1;
        wait_done(first_b, ok);
        check_eq("both_first_done", ok, 1);
        if (first_b) req_b = 1'b0; else req_a = 1'b0;
        wait_done(!first_b, ok);
        check_eq("both_second_done", ok, 1);
        req_a = 1'b0;
        req_b = 1'b0;
        model_seq = model_seq + 8'd2;
        @(negedge clk);
        check_eq("both_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  na, nb;
        bit  ok;
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; req_a2 = 1'b0; req_b2 = 1'b0;
        out_ready = 1'b1;
        ver_major = 8'h0B; ver_minor = 8'h00; ver_patch = 8'h00;
        model_seq = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        check_eq("por_fp", {grant_a2, grant_b2, out_valid2, busy2}, 0);
        rst = 1'b0;

        // Single A packet, 11.0.0: A5 0B 00 00 00 AE, done on 7th sample.
        run_packet(1'b0, 0, 0, 0, 8'h00, cyc);
        check_eq("single_latency", cyc, 7);

        // Both requesting from reset: A first, then B; then pointer favours B.
        do_reset();
        run_both(1'b0);
        run_packet(1'b0, 0, 0, 0, 8'h00, cyc);
        run_both(1'b1);

        // Three-cycle stall while idx2 is presented.
        run_packet(1'b0, 3, 3, 0, 8'h00, cyc);
        check_eq("stall_latency", cyc, 10);

        // Patch changes mid-packet; the snapshot rules this packet.
        do_reset();
        run_packet(1'b0, 0, 0, 2, 8'h07, cyc);
        run_packet(1'b0, 0, 0, 0, 8'h00, cyc);
        check_eq("post_change_latency", cyc, 7);
        ver_patch = 8'h00;

        // 257 packets: seq runs 00..FF and wraps to 00.
        do_reset();
        for (int p = 0; p < 257; p++) begin
            run_packet(1'b0, 0, 0, 0, 8'h00, cyc);
        end
        check_eq("wrap_model_seq", model_seq, 8'h01);

        // Reset while idx3 is presented, then a fresh seq-00 packet.
        do_reset();
        push_packet(1'b0, model_seq);
        @(negedge clk);
        req_a = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_last", out_data, last_pkt[3]);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        model_seq = 8'h00;
        push_packet(1'b0, model_seq);
        @(negedge clk);
        check_eq("rst_no_done", done_a, 0);
        rst = 1'b0;
        wait_done(1'b0, ok);
        check_eq("post_rst_done", ok, 1);
        req_a = 1'b0;
        model_seq = model_seq + 8'd1;
        @(negedge clk);

        // Fixed priority instance: A held continuously starves B.
        na = 0;
        nb = 0;
        req_a2 = 1'b1;
        req_b2 = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (grant_b2 || done_b2) nb++;
            if (done_a2) na++;
        end
        req_a2 = 1'b0;
        req_b2 = 1'b0;
        check_eq("fp_no_b", nb, 0);
        check_eq("fp_a_served", (na >= 8), 1);

        repeat (3) @(negedge clk);
        check_eq("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
